risc_controller: RTL and testbench
==================================

Name: risc_controller

Overview:
- Instruction sequencer for the 8-bit RISC CPU.
- Runs an 8-phase cycle per instruction. Decodes the 3-bit opcode latched in the instruction register and the ALU `is_zero` flag.
- Drives every datapath control strobe: address mux, memory read/write, IR/ACC/PC load, PC increment, data bus enable.
- Sits directly upstream of the ALU/accumulator path. Consumes the ALU zero flag and produces `ld_ac` to capture `alu_out`.

Parameters:
- PHASES, 8, number of phases per instruction (fixed; do not override).
- CNT_W, 16, width of the instruction-retire counter (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- opcode  input  3  opcode field from the instruction register
- is_zero  input  1  ALU zero flag (accumulator == 0)
- sel  output  1  address mux select: 1 = PC, 0 = IR operand address
- rd  output  1  memory read strobe
- ld_ir  output  1  load instruction register
- inc_pc  output  1  increment program counter
- ld_pc  output  1  load program counter from IR operand
- ld_ac  output  1  load accumulator from `alu_out`
- wr  output  1  memory write strobe
- data_e  output  1  drive accumulator onto the data bus
- halt  output  1  CPU halted
- retired  output  CNT_W  instructions retired

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst_n` is asynchronous, active-low.
- Opcode map: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
- ALUOP = ADD | AND | XOR | LDA.
- State: 3-bit phase register `ph` plus a 1-bit `halted` flag.
  - `ph` advances 0→1→…→7→0 every clock while `halted`=0.
- Outputs are combinational decode of `ph`, `opcode` and `is_zero`, gated by `halted`. Phases:
  - 0 INST_ADDR: sel=1.
  - 1 INST_FETCH: sel=1, rd=1.
  - 2 INST_LOAD: sel=1, rd=1, ld_ir=1.
  - 3 IDLE: sel=1, rd=1, ld_ir=1.
  - 4 OP_ADDR: inc_pc=1; halt=1 if opcode==HLT.
  - 5 OP_FETCH: rd=ALUOP.
  - 6 ALU_OP: rd=ALUOP; inc_pc=(SKZ & is_zero); ld_pc=JMP; data_e=STO.
  - 7 STORE: rd=ALUOP; ld_ac=ALUOP; inc_pc=JMP; ld_pc=JMP; wr=STO; data_e=STO.
- All strobes not listed for a phase are 0.
- Halt handling:
  - At the rising edge ending phase 4 with opcode==HLT, set `halted`=1 and freeze `ph`=4.
  - While halted: halt=1, all other outputs 0, `retired` frozen.
  - `halted` clears only on reset.
- is_zero and opcode are sampled combinationally each cycle. Changes mid-phase affect that phase's outputs only; the sequencer never latches them.
- SKZ takes effect only if is_zero=1 during phase 6. The PC is then incremented twice in the instruction: once in phase 4, once in phase 6.
- JMP: ld_pc and inc_pc are both high in phase 7. The PC block gives ld_pc priority.
- wr is asserted only in phase 7. data_e spans phases 6–7, giving one cycle of setup before wr.
- Reset, asynchronous, at any time including mid-instruction:
  - ph=0, halted=0, retired=0.
  - Outputs immediately: sel=1, all others 0, halt=0.
  - First phase after release is 0.
- Latency: exactly 8 cycles per non-HLT instruction. No stall input.

Optional Feature:
- Macro: RISC_CTRL_RETIRE_CNT_EN.
- Defined:
  - `retired` increments by 1 on each rising edge leaving phase 7 (7→0) while not halted.
  - Wraps from 2^CNT_W−1 to 0.
  - Reset to 0.
- Undefined: `retired` is tied to 0 and no counter flops are synthesised. The port remains, so the interface is unchanged.

Test Plan:
- Reset mid-run:
  - Stimulus: run 3 cycles, assert rst_n=0 asynchronously mid-cycle.
  - Response: ph=0, sel=1, all other outputs 0, halt=0 before the next edge; phase 0 after release.
- ADD (opcode=010) over one instruction:
  - Phases 0–3: sel=1.
  - rd=1 in phases 1,2,3,5,6,7; ld_ir=1 in phases 2–3; inc_pc=1 in phase 4; ld_ac=1 in phase 7 only.
  - wr=data_e=ld_pc=0 throughout.
- SKZ (001):
  - is_zero=1: inc_pc high in phases 4 and 6 (2 pulses).
  - is_zero=0: inc_pc high in phase 4 only; rd=0 in phases 5–7.
- STO (110):
  - data_e=1 in phases 6–7, wr=1 in phase 7 only, rd=0 in phases 5–7, ld_ac=0.
- JMP (111):
  - ld_pc=1 in phases 6–7, inc_pc=1 in phases 4 and 7.
  - Next instruction starts at phase 0 with sel=1.
- HLT (000) after 3 ADDs, macro defined:
  - halt=1 in phase 4, then held; ph frozen; all other strobes 0 for 20+ cycles.
  - retired=3, unchanged while halted; reset clears halt and retired.

Source files
------------

// File: rtl/risc_controller_if.sv
// Bus bundle between the RISC instruction sequencer and its datapath.
// The controller takes the master view. It samples opcode/is_zero and drives
// every control strobe plus the retired-instruction count.
interface risc_controller_if #(
  parameter int CNT_W = 16
);
  logic [2:0]       opcode;
  logic             is_zero;
  logic             sel;
  logic             rd;
  logic             ld_ir;
  logic             inc_pc;
  logic             ld_pc;
  logic             ld_ac;
  logic             wr;
  logic             data_e;
  logic             halt;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, is_zero,
    output sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, retired
  );

  modport slave (
    output opcode, is_zero,
    input  sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, retired
  );
endinterface

// File: rtl/risc_controller.sv
// Eight-phase instruction sequencer for the 8-bit RISC CPU.
// Strobes are a combinational decode of the phase register, the opcode and
// the ALU zero flag. All strobes except halt are forced low once the CPU halts.
// Optional feature: define RISC_CTRL_RETIRE_CNT_EN to build the
// instruction-retire counter. When it is not defined, 'retired' is tied to 0.
module risc_controller #(
  parameter int PHASES = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  risc_controller_if.master bus
);

  typedef enum logic [2:0] {
    PH_INST_ADDR  = 3'd0,
    PH_INST_FETCH = 3'd1,
    PH_INST_LOAD  = 3'd2,
    PH_IDLE       = 3'd3,
    PH_OP_ADDR    = 3'd4,
    PH_OP_FETCH   = 3'd5,
    PH_ALU_OP     = 3'd6,
    PH_STORE      = 3'd7
  } phase_e;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Last phase of an instruction; the phase register wraps from here to 0.
  localparam phase_e PH_LAST = phase_e'(3'(PHASES - 1));

  phase_e ph_q, ph_d;
  logic   halted_q, halted_d;

  logic aluop_s, is_skz_s, is_sto_s, is_jmp_s, is_hlt_s;
  logic sel_s, rd_s, ld_ir_s, inc_pc_s, ld_pc_s, ld_ac_s, wr_s, data_e_s, halt_s;

  // Opcode class decode; opcode is never latched here.
  always_comb begin
    aluop_s  = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
               (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);
    is_skz_s = (bus.opcode == OP_SKZ);
    is_sto_s = (bus.opcode == OP_STO);
    is_jmp_s = (bus.opcode == OP_JMP);
    is_hlt_s = (bus.opcode == OP_HLT);
  end

  // Phase and halt flag registers; halt is only left through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q     <= PH_INST_ADDR;
      halted_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      halted_q <= halted_d;
    end
  end

  // Next-phase logic and per-phase strobe decode.
  always_comb begin
    ph_d     = ph_q;
    halted_d = halted_q;
    sel_s    = 1'b0;
    rd_s     = 1'b0;
    ld_ir_s  = 1'b0;
    inc_pc_s = 1'b0;
    ld_pc_s  = 1'b0;
    ld_ac_s  = 1'b0;
    wr_s     = 1'b0;
    data_e_s = 1'b0;
    halt_s   = 1'b0;
    if (halted_q) begin
      halt_s = 1'b1;
    end else begin
      ph_d = (ph_q == PH_LAST) ? PH_INST_ADDR : phase_e'(ph_q + 3'd1);
      case (ph_q)
        PH_INST_ADDR: begin
          sel_s = 1'b1;
        end
        PH_INST_FETCH: begin
          sel_s = 1'b1;
          rd_s  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel_s   = 1'b1;
          rd_s    = 1'b1;
          ld_ir_s = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc_s = 1'b1;
          if (is_hlt_s) begin
            // Freeze on phase 4 so the stopped state is easy to identify.
            halt_s   = 1'b1;
            halted_d = 1'b1;
            ph_d     = PH_OP_ADDR;
          end else begin
            halt_s   = 1'b0;
          end
        end
        PH_OP_FETCH: begin
          rd_s = aluop_s;
        end
        PH_ALU_OP: begin
          rd_s     = aluop_s;
          inc_pc_s = is_skz_s & bus.is_zero;
          ld_pc_s  = is_jmp_s;
          data_e_s = is_sto_s;
        end
        PH_STORE: begin
          // JMP raises both PC strobes; the PC block gives ld_pc priority.
          rd_s     = aluop_s;
          ld_ac_s  = aluop_s;
          inc_pc_s = is_jmp_s;
          ld_pc_s  = is_jmp_s;
          wr_s     = is_sto_s;
          data_e_s = is_sto_s;
        end
        default: begin
          sel_s = 1'b1;
        end
      endcase
    end
  end

  // Strobes drive the datapath bus directly.
  assign bus.sel    = sel_s;
  assign bus.rd     = rd_s;
  assign bus.ld_ir  = ld_ir_s;
  assign bus.inc_pc = inc_pc_s;
  assign bus.ld_pc  = ld_pc_s;
  assign bus.ld_ac  = ld_ac_s;
  assign bus.wr     = wr_s;
  assign bus.data_e = data_e_s;
  assign bus.halt   = halt_s;

`ifdef RISC_CTRL_RETIRE_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;

  // Count one instruction at each edge that leaves the last phase.
  always_comb begin
    if (!halted_q && (ph_q == PH_LAST)) begin
      retired_d = retired_q + CNT_W'(1);
    end else begin
      retired_d = retired_q;
    end
  end

  // Retire counter register; it wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= {CNT_W{1'b0}};
    end else begin
      retired_q <= retired_d;
    end
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_risc_controller.sv
// Directed bench for risc_controller. Each step drives opcode and is_zero,
// pushes the expected strobes onto a scoreboard queue, then pops the entry and
// compares it with the DUT outputs 1 ns later. A phase/halt/retire model in
// the bench advances the expected state at each rising edge.
module tb_risc_controller;
  localparam int CNT_W = 16;
  localparam logic [2:0] HLT = 3'b000;
  localparam logic [2:0] SKZ = 3'b001;
  localparam logic [2:0] ADD = 3'b010;
  localparam logic [2:0] AND = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] LDA = 3'b101;
  localparam logic [2:0] STO = 3'b110;
  localparam logic [2:0] JMP = 3'b111;

  logic clk;
  logic rst_n;

  risc_controller_if #(.CNT_W(CNT_W)) bus();

  risc_controller #(.PHASES(8), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               m_ph = 0;
  logic             m_halted = 1'b0;
  logic [CNT_W-1:0] m_ret = '0;
  logic [8:0]       sb_q[$];

  // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt} for one phase.
  function automatic logic [8:0] exp_vec(input int ph, input logic [2:0] op,
                                         input logic z, input logic hlt);
    logic s, r, li, ip, lp, la, w, de, h, alu;
    {s, r, li, ip, lp, la, w, de, h} = 9'b0;
    alu = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
    if (hlt) return 9'b0_0000_0001;
    case (ph)
      0: s = 1'b1;
      1: begin s = 1'b1; r = 1'b1; end
      2, 3: begin s = 1'b1; r = 1'b1; li = 1'b1; end
      4: begin ip = 1'b1; h = (op == HLT); end
      5: r = alu;
      6: begin r = alu; ip = (op == SKZ) && z; lp = (op == JMP); de = (op == STO); end
      7: begin r = alu; la = alu; ip = (op == JMP); lp = (op == JMP);
               w = (op == STO); de = (op == STO); end
      default: s = 1'b0;
    endcase
    return {s, r, li, ip, lp, la, w, de, h};
  endfunction

  task automatic cmp_out(input string tag);
    logic [8:0] exp_v;
    logic [8:0] obs_v;
    exp_v = sb_q.pop_front();
    obs_v = {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.ld_pc, bus.ld_ac,
             bus.wr, bus.data_e, bus.halt};
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL %s ph=%0d strobes observed=%b expected=%b", tag, m_ph, obs_v, exp_v);
    end
    checks++;
    assert (bus.retired === m_ret) else begin
      errors++;
      $error("FAIL %s_retired ph=%0d observed=%0d expected=%0d", tag, m_ph, bus.retired, m_ret);
    end
  endtask

  // Drive one cycle, check it, then advance the model across the rising edge.
  task automatic step(input logic [2:0] op, input logic z, input string tag);
    bus.opcode  = op;
    bus.is_zero = z;
    sb_q.push_back(exp_vec(m_ph, op, z, m_halted));
    #1;
    cmp_out(tag);
    @(posedge clk);
    #1;
    if (!m_halted) begin
      if (m_ph == 4 && op == HLT) begin
        m_halted = 1'b1;
      end else begin
`ifdef RISC_CTRL_RETIRE_CNT_EN
        if (m_ph == 7) m_ret = m_ret + 1'b1;
`endif
        m_ph = (m_ph + 1) % 8;
      end
    end
  endtask

  task automatic instr(input logic [2:0] op, input logic z, input string tag);
    for (int p = 0; p < 8; p++) step(op, z, tag);
  endtask

  // Assert reset mid-cycle and check the outputs before the next edge.
  task automatic async_reset(input string tag);
    #3;
    rst_n = 1'b0;
    #1;
    m_ph = 0;
    m_halted = 1'b0;
    m_ret = '0;
    sb_q.push_back(exp_vec(0, bus.opcode, bus.is_zero, 1'b0));
    cmp_out(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    bus.opcode = ADD;
    bus.is_zero = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(exp_vec(0, ADD, 1'b0, 1'b0));
    cmp_out("RST_INIT");
    @(negedge clk);
    rst_n = 1'b1;

    // Run three cycles, then reset in the middle of the instruction.
    for (int i = 0; i < 3; i++) step(ADD, 1'b0, "RUN3");
    async_reset("RST_MID");

    instr(ADD, 1'b0, "ADD");
    instr(SKZ, 1'b1, "SKZ_Z1");
    instr(SKZ, 1'b0, "SKZ_Z0");
    instr(STO, 1'b0, "STO");
    instr(JMP, 1'b0, "JMP");
    instr(AND, 1'b1, "AND");
    instr(XOR, 1'b0, "XOR");
    instr(LDA, 1'b1, "LDA");

    // Three ADDs and a HLT, then a long halted stretch with random inputs.
    async_reset("RST_PRE_HLT");
    instr(ADD, 1'b0, "ADD_A");
    instr(ADD, 1'b1, "ADD_B");
    instr(ADD, 1'b0, "ADD_C");
    for (int p = 0; p < 5; p++) step(HLT, 1'b0, "HLT");
    for (int i = 0; i < 24; i++)
      step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), "HALTED");

    // Reset leaves the halted state, and the sequencer runs again.
    async_reset("RST_POST_HLT");
    instr(ADD, 1'b0, "ADD_AFTER");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
